// File: rtl/data_bus_responder.sv
// data_bus_responder
//   Target side of the core's data-memory port. Decodes every load/store and
//   services it from a byte-addressable RAM or a 32-byte MMIO window.
//   Loads are combinational so a single-cycle core completes them in the
//   same cycle; stores commit on the rising edge.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   addr_in         byte address of the access
//   data_in         store data (low bits used for byte/half stores)
//   wr_en, rd_en    store / load strobes (both high = store)
//   fn3             access size and load signedness
//   btn             raw asynchronous active-low button
//   data_out        extended load result, 0 when idle or faulting
//   fault           current access is illegal (combinational)
//   fault_sticky    a fault has been seen since reset
//   fault_addr      address of the first fault since reset
//   leds_reg        LED register
//   tohost_valid    program has written tohost with bit0 set (sticky)
//   tohost_value    last value written to tohost
//
// MMIO map (word access only): +00 LED, +04 BTN, +08 CYCLE lo,
//   +0C CYCLE hi, +10 TOHOST; remaining offsets read 0 and ignore writes.
module data_bus_responder #(
  parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
  parameter int          RAM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [2:0]  fn3,
  input  logic        btn,
  output logic [31:0] data_out,
  output logic        fault,
  output logic        fault_sticky,
  output logic [31:0] fault_addr,
  output logic [5:0]  leds_reg,
  output logic        tohost_valid,
  output logic [31:0] tohost_value
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  // ---------------- decode ----------------
  logic [31:0]   ram_off;
  logic          in_ram;
  logic          in_mmio;
  logic [AW-1:0] word_idx;
  logic [2:0]    mmio_sel;

  // Single unsigned compare covers both "below base" and "past the end".
  assign ram_off  = addr_in - RAM_BASE;
  assign in_ram   = (ram_off < RAM_BYTES);
  assign in_mmio  = (addr_in[31:5] == MMIO_BASE[31:5]);
  assign word_idx = ram_off[AW+1:2];
  assign mmio_sel = addr_in[4:2];

  logic size_half;
  logic size_word;
  logic fn3_bad;
  logic misalign;
  logic mmio_bad;

  assign size_half = (fn3[1:0] == 2'b01);
  assign size_word = (fn3[1:0] == 2'b10);
  // 011/110/111 are never legal; 100/101 (unsigned) make no sense for a store.
  assign fn3_bad   = (fn3[1:0] == 2'b11) || (fn3[2] && (fn3[1] || wr_en));
  assign misalign  = (size_half && addr_in[0]) || (size_word && (addr_in[1:0] != 2'b00));
  assign mmio_bad  = in_mmio && (fn3 != 3'b010);
  assign fault     = (rd_en || wr_en) &&
                     (fn3_bad || misalign || !(in_ram || in_mmio) || mmio_bad);

  // ---------------- RAM ----------------
  logic [3:0]  lane_en;
  logic [31:0] wr_data;
  logic [31:0] rd_word;
  logic        ram_we;
  logic        mmio_we;

  always_comb begin
    lane_en = 4'b1111;
    wr_data = data_in;
    case (fn3[1:0])
      2'b00: begin
        lane_en = 4'b0001 << addr_in[1:0];
        wr_data = {4{data_in[7:0]}};
      end
      2'b01: begin
        lane_en = addr_in[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{data_in[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM stores are not gated by reset; MMIO stores are.
  assign ram_we  = wr_en && !fault && in_ram;
  assign mmio_we = wr_en && !fault && in_mmio;

  // One byte-wide array per lane so partial stores need no read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [RAM_WORDS];
      always_ff @(posedge clk) begin
        if (ram_we && lane_en[gi]) begin
          mem[word_idx] <= wr_data[8*gi +: 8];
        end
      end
      assign rd_word[8*gi +: 8] = mem[word_idx];
    end
  endgenerate

  // ---------------- MMIO state ----------------
  logic [63:0] cycle_reg;
  logic        btn_meta_reg;
  logic        btn_sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_reg     <= '0;
      tohost_valid <= 1'b0;
      tohost_value <= '0;
      cycle_reg    <= '0;
      btn_meta_reg <= 1'b0;
      btn_sync_reg <= 1'b0;
      fault_sticky <= 1'b0;
      fault_addr   <= '0;
    end else begin
      cycle_reg    <= cycle_reg + 64'd1;
      btn_meta_reg <= ~btn;
      btn_sync_reg <= btn_meta_reg;
      if (mmio_we) begin
        case (mmio_sel)
          3'd0: leds_reg <= data_in[5:0];
          3'd4: begin
            tohost_value <= data_in;
            if (data_in[0]) tohost_valid <= 1'b1;
          end
          default: ;
        endcase
      end
      if (fault && !fault_sticky) begin
        fault_sticky <= 1'b1;
        fault_addr   <= addr_in;
      end
    end
  end

  // ---------------- load path ----------------
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ram_rd_data;
  logic [31:0] mmio_rd_data;

  always_comb begin
    case (addr_in[1:0])
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = addr_in[1] ? rd_word[31:16] : rd_word[15:0];

    case (fn3)
      3'b000:  ram_rd_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ram_rd_data = {24'd0, sel_byte};
      3'b001:  ram_rd_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  ram_rd_data = {16'd0, sel_half};
      default: ram_rd_data = rd_word;
    endcase

    case (mmio_sel)
      3'd0:    mmio_rd_data = {26'd0, leds_reg};
      3'd1:    mmio_rd_data = {31'd0, btn_sync_reg};
      3'd2:    mmio_rd_data = cycle_reg[31:0];
      3'd3:    mmio_rd_data = cycle_reg[63:32];
      3'd4:    mmio_rd_data = tohost_value;
      default: mmio_rd_data = 32'd0;
    endcase

    if (!rd_en || fault) data_out = 32'd0;
    else if (in_ram)     data_out = ram_rd_data;
    else if (in_mmio)    data_out = mmio_rd_data;
    else                 data_out = 32'd0;
  end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Responder (target) end of the core's data-memory interface: decodes each load/store the core issues (address, store data, write enable, funct3) and services it from a byte-addressable RAM or a small memory-mapped I/O region. Handles byte/half/word sizing, load sign/zero extension and alignment checks. Provides the LED register, synchronised button status, a free-running 64-bit cycle counter and a `tohost` completion register. Sits beside the core in place of the plain simulation data memory; reads are combinational so the single-cycle core completes a load in the same cycle.

## Interface
- `RAM_BASE`, 32'h80000000, byte base address of RAM
- `RAM_WORDS`, 4096, RAM depth in 32-bit words (power of two)
- `MMIO_BASE`, 32'h10000000, byte base of the 32-byte MMIO window
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `addr_in`  in  32  byte address (core ALU output)
- `data_in`  in  32  store data (rs2)
- `wr_en`  in  1  store this cycle
- `rd_en`  in  1  load this cycle (core load decode)
- `fn3`  in  3  access size/sign (instruction[14:12])
- `btn`  in  1  raw asynchronous button, active-low
- `data_out`  out  32  load result, extended per `fn3`
- `fault`  out  1  combinational: current access is illegal
- `fault_sticky`  out  1  a fault has occurred since reset
- `fault_addr`  out  32  address of first fault
- `leds_reg`  out  6  LED register contents
- `tohost_valid`  out  1  sticky: program wrote `tohost` with bit0=1
- `tohost_value`  out  32  last value written to `tohost`

## Operation
- `fn3`: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 illegal. Stores use only size (000/001/010); store with 100/101 is illegal.
- Decode: RAM if `addr_in - RAM_BASE < RAM_WORDS*4` (unsigned 32-bit); MMIO if `addr_in[31:5] == MMIO_BASE[31:5]`; else unmapped.
- RAM word index `(addr_in - RAM_BASE) >> 2`, wraps mod `RAM_WORDS` never needed (range checked). Store writes only enabled byte lanes: byte lane `addr[1:0]`, half lanes `{addr[1],0}` pair, word all four; store data taken from `data_in` low bits, replicated to the lane.
- Load: select byte/half at `addr[1:0]`, sign- or zero-extend to 32 bits.
- MMIO (word access only, `fn3`=010): +0x00 LED R/W (bits[5:0]; reads upper bits 0); +0x04 BTN RO, bit0 = synchronised `~btn`; +0x08 CYCLE[31:0] RO; +0x0C CYCLE[63:32] RO; +0x10 TOHOST W/R: write latches `tohost_value`, sets `tohost_valid` if `data_in[0]`; read returns `tohost_value`. Other offsets: read 0, write ignored, no fault.
- `fault` = `(rd_en|wr_en)` and any of: illegal `fn3`; half not 2-aligned; word not 4-aligned; unmapped; MMIO with `fn3`≠010. Faulting stores modify nothing; faulting loads return 0.
- `rd_en` and `wr_en` both high: treated as store; `data_out` still shows old contents.
- When `rd_en`=0, `data_out`=0.

## Timing
- Loads: combinational from `addr_in`/`fn3`, zero latency; reflects state before the current edge.
- Stores: commit on the rising edge where `wr_en`=1; visible to a load the following cycle.
- Cycle counter: increments every cycle after reset, 64-bit, wraps to 0 at 2^64-1; value read is pre-increment for that cycle.
- Button: two-flop synchroniser; BTN reflects a `btn` change 2 cycles later.
- `fault_sticky`/`fault_addr` set on the first rising edge with `fault`=1; later faults do not update `fault_addr`.
- `tohost_valid` stays 1 until reset, even if later written with bit0=0.
- Reset (edge with `rst`=1): `leds_reg`=0, `tohost_valid`=0, `tohost_value`=0, cycle=0, sync flops=0 (BTN reads 1 only after real release/press sampling), `fault_sticky`=0, `fault_addr`=0. RAM contents not reset. A store coincident with `rst` to MMIO is dropped; to RAM it commits.

## Test plan
- SW 0xDEADBEEF @0x80000010, then LB/LBU @0x80000013, LH/LHU @0x80000012, LW @0x80000010 -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF.
- SB 0x12 @0x80000011 over 0xDEADBEEF -> LW reads 0xDEAD12EF; SH 0x5678 @0x80000012 -> 0x567812EF.
- LW @0x80000002, SH @0x80000001, LW @0x00000000, fn3=011 each -> `fault`=1, no RAM change, `fault_addr`=0x80000002 (first), `fault_sticky`=1.
- SW 0x3F to LED, LW LED -> `leds_reg`=6'h3F, read 0x3F; SB to LED -> fault, LED unchanged.
- Release reset, LW CYCLE lo at cycle N then N+5 -> difference 5; preload near 2^32 boundary by running, check CYCLE hi increments when lo wraps.
- SW 0x1 to TOHOST -> `tohost_valid`=1 next cycle, `tohost_value`=1; SW 0x0 -> valid stays 1, value 0; assert `rst` -> both 0.
